uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter with an internal baud counter, a ready/valid byte interface, configurable data width, parity and stop bits. It serialises one frame per accepted word onto `tx_pin_out`, LSB first, and pulses `tx_done_sig` when the frame completes. It sits between any byte producer (FIFO, command sequencer) and the board TX pin. It replaces the fixed 8N1, external-`bps_clk` transmitter in new designs.

## Interface
- `CLKS_PER_BIT`, 434: `clk` cycles per bit (50 MHz / 115200). Legal range is ≥ 2.
- `DATA_BITS`, 8: data bits per frame. Legal range is 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- Any illegal parameter value is an elaboration-time error.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_data`  in  DATA_BITS  word to send. Sampled only at handshake.
- `tx_ready`  out  1  block can accept a word.
- `tx_busy`  out  1  a frame is in progress.
- `tx_done_sig`  out  1  one-cycle pulse at frame end.
- `tx_pin_out`  out  1  serial line. Idle high.

## Operation
- Handshake: a word is accepted on a rising edge where `tx_valid && tx_ready`.
- At acceptance, `tx_data` is latched into a shift register and parity is computed from the latched value.
- The source may change `tx_data` freely after acceptance.
- State machine (from the shared package): IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when `PARITY = 0`.
- IDLE: `tx_pin_out = 1`, `tx_ready = 1`, `tx_busy = 0`.
- START: line 0 for one bit time.
- DATA: `DATA_BITS` bit times, shift register LSB first. A bit index counter runs 0..DATA_BITS-1.
- PARITY: one bit time.
  - Odd: the parity bit makes the total number of ones across data + parity odd.
  - Even: the total is even.
- STOP: line 1 for `STOP_BITS` bit times. On the edge ending the last stop bit:
  - state → IDLE;
  - `tx_done_sig = 1` for exactly that following cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Cleared to 0 at acceptance.
  - Each wrap advances the bit position.
  - Free of drift: every bit lasts exactly `CLKS_PER_BIT` cycles.
- `tx_valid` asserted while busy is ignored, not queued. `tx_ready` stays 0 until IDLE.
- Reset values:
  - `tx_pin_out = 1`
  - `tx_ready = 1`
  - `tx_busy = 0`
  - `tx_done_sig = 0`
  - state IDLE, counters 0.
- Reset asserted mid-frame: the line returns high immediately (asynchronous) and the partial frame is discarded. No `tx_done_sig` is issued.

## Timing
- All outputs are registered, or decoded directly from registered state.
- `tx_ready` and `tx_busy` are never both 1 or both 0.
- Handshake on edge T: `tx_pin_out` goes 0 from T (visible in cycle T+1). `tx_busy = 1` and `tx_ready = 0` from the same edge.
- Frame length N = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from edge T to the edge that returns to IDLE.
- `tx_done_sig` and `tx_ready` rise on the same edge (T+N).
- Back-to-back: if `tx_valid` is high in the IDLE cycle, the next start bit begins on edge T+N+1. The final stop bit therefore lasts CLKS_PER_BIT+1 cycles in streaming mode.
- Maximum throughput is one frame per N+1 cycles.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants `PAR_NONE/PAR_ODD/PAR_EVEN`;
  - the width function for the baud counter, `$clog2(CLKS_PER_BIT)`.
- One sub-module, `uart_baud_tick`, parameter `CLKS_PER_BIT`:
  - inputs `clk`, `rstn`, `clear`, `run`;
  - output `tick` (one cycle at counter wrap).
  - It will be reused by the future receiver.
- FSM, shift register and bit/stop counters live in `uart_tx_frame`.

## Test plan
- 8N1, CLKS_PER_BIT = 4, send 0xA5:
  - line is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - `tx_done_sig` single pulse at cycle 40 after the handshake.
- DATA_BITS = 7, PARITY = 2 (even), send 0x03: parity bit 0. PARITY = 1 (odd), send 0x03: parity bit 1. Frame length 40 cycles with STOP_BITS = 1.
- STOP_BITS = 2, `tx_valid` held high, words 0x00 then 0xFF:
  - second start bit begins exactly 1 cycle after the first `tx_done_sig`;
  - gap is 9 high cycles.
- `tx_valid` pulsed with 0x55 during busy: ignored. The line carries only the first word and `tx_ready` stays 0 until IDLE.
- `rstn` asserted in the middle of data bit 3: the line goes high asynchronously with no `tx_done_sig`. After release, 0x3C is sent correctly.
- Change `tx_data` every cycle after handshake with 0x81 latched: the transmitted bits still match 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and
// baud counter sizing, common to the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and
// pulses tick in the last cycle of each bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic run,
  output logic tick
);
  import uart_pkg::*;

  localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear takes priority so a new frame always starts on a full bit period.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word per ready/valid handshake and sends
// start, LSB-first data, optional parity and stop bits on tx_pin_out.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | line low for one bit time
// DATA   | shift register LSB on line, DATA_BITS bit times
// PARITY | computed parity bit, one bit time
// STOP   | line high for STOP_BITS bit times, done pulse at the end
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done_sig,
  output logic                 tx_pin_out
);
  import uart_pkg::*;

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_q, par_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 tick;

  assign tx_ready    = (state_q == IDLE);
  assign tx_busy     = ~tx_ready;
  assign tx_done_sig = done_q;
  assign accept      = tx_valid & tx_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rstn  (rstn),
    .clear (accept),
    .run   (tx_busy),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = START;
          shift_d    = tx_data;
          par_d      = (^tx_data) ^ (PARITY == PAR_ODD);
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d    = IDLE;
            stop_idx_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line decoded from registered state so reset forces it high at once.
  always_comb begin
    tx_pin_out = 1'b1;
    case (state_q)
      START:            tx_pin_out = 1'b0;
      DATA:             tx_pin_out = shift_q[0];
      uart_pkg::PARITY: tx_pin_out = par_q;
      default:          tx_pin_out = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four configurations (8N1, 7E1, 7O1,
// 8N2) with hand-computed frames checked cycle by cycle by per-lane monitors.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    bit          abort;
    bit          stream;
  } frame_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] valid = '0;
  logic [8:0] data [4];
  logic [3:0] ready, busy, done, pin;

  frame_t exp_q [4][$];
  bit     stream_pend [4];
  int     n_checks = 0;
  int     n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rstn(rstn), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done_sig(done[0]), .tx_pin_out(pin[0]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rstn(rstn), .tx_valid(valid[1]), .tx_data(data[1][6:0]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done_sig(done[1]), .tx_pin_out(pin[1]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rstn(rstn), .tx_valid(valid[2]), .tx_data(data[2][6:0]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done_sig(done[2]), .tx_pin_out(pin[2]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rstn(rstn), .tx_valid(valid[3]), .tx_data(data[3][7:0]),
    .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done_sig(done[3]), .tx_pin_out(pin[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_frame(input int i, input logic [15:0] b, input int n,
                              input bit ab, input bit st);
    frame_t f;
    f.bits   = b;
    f.nbits  = n;
    f.abort  = ab;
    f.stream = st;
    exp_q[i].push_back(f);
  endtask

  // Follows one frame from the negedge after the handshake edge (c = 0).
  task automatic run_frame(input int i);
    frame_t      e;
    int          n;
    int          bad_line;
    int          bad_ctl;
    bit          ab;
    logic [15:0] obs;
    bad_line = 0;
    bad_ctl  = 0;
    ab       = 1'b0;
    obs      = '0;
    chk($sformatf("frame_expected_lane%0d", i), {31'b0, exp_q[i].size() > 0}, 32'd1);
    if (exp_q[i].size() == 0) begin
      for (int k = 0; k < 200 && busy[i]; k++) @(negedge clk);
      return;
    end
    e = exp_q[i].pop_front();
    n = e.nbits * CPB;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      if (!rstn) begin
        ab = 1'b1;
        break;
      end
      if (c % CPB == CPB / 2) obs[c / CPB] = pin[i];
      if (pin[i] !== e.bits[c / CPB]) bad_line++;
      if (ready[i] !== 1'b0 || busy[i] !== 1'b1 || done[i] !== 1'b0) bad_ctl++;
    end
    chk($sformatf("aborted_lane%0d", i), {31'b0, ab}, {31'b0, e.abort});
    if (ab) begin
      chk("abort_line_high", {31'b0, pin[i]}, 32'd1);
      chk("abort_no_done", {31'b0, done[i]}, 32'd0);
      chk("abort_prefix_line", bad_line, 0);
      return;
    end
    chk($sformatf("frame_bits_lane%0d", i), {16'b0, obs}, {16'b0, e.bits});
    chk($sformatf("line_cycles_bad_lane%0d", i), bad_line, 0);
    chk($sformatf("ctrl_cycles_bad_lane%0d", i), bad_ctl, 0);
    @(negedge clk);
    chk($sformatf("done_ready_line_at_N_lane%0d", i), {29'b0, done[i], ready[i], pin[i]}, 32'b111);
    stream_pend[i] = e.stream;
  endtask

  task automatic mon(input int i);
    bit prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_busy      = 1'b0;
        stream_pend[i] = 1'b0;
        continue;
      end
      chk($sformatf("ready_xor_busy_lane%0d", i), {31'b0, ready[i] ^ busy[i]}, 32'd1);
      chk($sformatf("done_outside_end_lane%0d", i), {31'b0, done[i]}, 32'd0);
      if (stream_pend[i]) begin
        chk($sformatf("stream_restart_lane%0d", i), {30'b0, busy[i], pin[i]}, 32'b10);
        stream_pend[i] = 1'b0;
      end
      if (busy[i] && !prev_busy) run_frame(i);
      prev_busy = busy[i];
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);

  task automatic send(input int i, input logic [8:0] d, input bit keep_valid);
    @(negedge clk);
    data[i]  = d;
    valid[i] = 1'b1;
    for (int k = 0; k < 200 && !ready[i]; k++) @(negedge clk);
    chk($sformatf("ready_for_send_lane%0d", i), {31'b0, ready[i]}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 500 && busy[i]; k++) @(negedge clk);
    chk($sformatf("idle_reached_lane%0d", i), {31'b0, busy[i]}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data[i] = '0;
    rstn = 1'b0;
    #12;
    chk("reset_line", {28'b0, pin}, 32'hF);
    chk("reset_ready", {28'b0, ready}, 32'hF);
    chk("reset_busy", {28'b0, busy}, 32'h0);
    chk("reset_done", {28'b0, done}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    expect_frame(0, 16'h034A, 10, 1'b0, 1'b0);
    send(0, 9'h0A5, 1'b0);
    wait_idle(0);

    // 7E1 and 7O1 with 0x03: parity 0 and 1
    expect_frame(1, 16'h0206, 10, 1'b0, 1'b0);
    send(1, 9'h003, 1'b0);
    wait_idle(1);
    expect_frame(2, 16'h0306, 10, 1'b0, 1'b0);
    send(2, 9'h003, 1'b0);
    wait_idle(2);

    // 8N2 streaming 0x00 then 0xFF with valid held high
    expect_frame(3, 16'h0600, 11, 1'b0, 1'b1);
    expect_frame(3, 16'h07FE, 11, 1'b0, 1'b0);
    send(3, 9'h000, 1'b1);
    data[3] = 9'h0FF;
    for (int k = 0; k < 200 && !ready[3]; k++) @(negedge clk);
    chk("stream_ready_again", {31'b0, ready[3]}, 32'd1);
    @(posedge clk);
    #1;
    valid[3] = 1'b0;
    wait_idle(3);

    // 0x0F with a 0x55 valid pulse while busy
    expect_frame(0, 16'h021E, 10, 1'b0, 1'b0);
    send(0, 9'h00F, 1'b0);
    repeat (10) @(negedge clk);
    data[0]  = 9'h055;
    valid[0] = 1'b1;
    @(negedge clk);
    chk("ready_low_while_busy", {31'b0, ready[0]}, 32'd0);
    valid[0] = 1'b0;
    wait_idle(0);
    repeat (10) @(negedge clk);

    // 0x81 latched, tx_data scrambled every cycle afterwards
    expect_frame(0, 16'h0302, 10, 1'b0, 1'b0);
    send(0, 9'h081, 1'b0);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      data[0] = 9'($urandom);
    end
    wait_idle(0);

    // 0x52 interrupted by reset in data bit 3 (a 0 bit), then 0x3C
    expect_frame(0, 16'h02A4, 10, 1'b1, 1'b0);
    send(0, 9'h052, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    chk("line_before_reset", {31'b0, pin[0]}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("line_async_high", {31'b0, pin[0]}, 32'd1);
    chk("no_done_on_reset", {31'b0, done[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    expect_frame(0, 16'h0278, 10, 1'b0, 1'b0);
    send(0, 9'h03C, 1'b0);
    wait_idle(0);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("queue_empty_lane%0d", i), exp_q[i].size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
